// File: rtl/mem_req_unit_if.sv
// Data-side bus between the load/store request unit and memory.
// The master drives req/we/wstrb/addr/wdata. The slave returns gnt and read data.
interface mem_req_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  localparam int BYTES = DATA_W / 8;

  logic              req;
  logic              gnt;
  logic              we;
  logic [BYTES-1:0]  wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, wstrb, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, wstrb, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_req_unit.sv
// Load/store request unit sitting between the EX/MEM boundary and the data bus.
// It handles one access at a time, with lane steering, misalignment traps and flush-driven cancellation.
module mem_req_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_ale,
  output logic [ADDR_W-1:0] resp_badv,
  mem_req_unit_if.master    da
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFS_W = $clog2(BYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state;
  logic             drop;
  logic [1:0]       size_p1;
  logic             uns_p1;
  logic [OFS_W-1:0] ofs_p1;

  logic             accept;
  logic             misaligned;
  logic [OFS_W-1:0] ofs;

  function automatic logic [2:0] size_mask(input logic [1:0] size);
    logic [2:0] m;
    case (size)
      2'd0:    m = 3'b000;
      2'd1:    m = 3'b001;
      2'd2:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  function automatic logic [BYTES-1:0] store_strobe(input logic [1:0] size,
                                                    input logic [OFS_W-1:0] lane);
    logic [BYTES-1:0] base;
    for (int i = 0; i < BYTES; i++) begin
      base[i] = (i < (1 << size));
    end
    return base << lane;
  endfunction

  // Signed temporaries make the cast below sign-extend. The unsigned path zero-fills.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] lane,
                                                    input logic [1:0] size,
                                                    input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic [DATA_W-1:0]  r;
    b = lane[7:0];
    h = lane[15:0];
    w = lane[31:0];
    case (size)
      2'd0:    r = uns ? DATA_W'(lane[7:0])  : DATA_W'(b);
      2'd1:    r = uns ? DATA_W'(lane[15:0]) : DATA_W'(h);
      2'd2:    r = uns ? DATA_W'(lane[31:0]) : DATA_W'(w);
      default: r = lane;
    endcase
    return r;
  endfunction

  assign ofs        = req_addr[OFS_W-1:0];
  assign req_ready  = (state == S_IDLE) && !flush && !rst;
  assign accept     = req_valid && req_ready;
  assign misaligned = ((req_addr[2:0] & size_mask(req_size)) != 3'b000) ||
                      ((req_size == 2'd3) && (DATA_W == 32));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      drop       <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_ale   <= 1'b0;
      resp_badv  <= '0;
      da.req     <= 1'b0;
      da.we      <= 1'b0;
      da.wstrb   <= '0;
      da.addr    <= '0;
      da.wdata   <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_ale   <= 1'b0;
      resp_badv  <= '0;
      case (state)
        // p0 -> p1: request capture, either a trap response or a bus request.
        S_IDLE: begin
          if (accept) begin
            if (misaligned) begin
              resp_valid <= 1'b1;
              resp_ale   <= 1'b1;
              resp_badv  <= req_addr;
            end else begin
              da.req   <= 1'b1;
              da.we    <= req_we;
              da.addr  <= {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
              da.wstrb <= req_we ? store_strobe(req_size, ofs) : '0;
              da.wdata <= req_we ? (req_wdata << {ofs, 3'b000}) : '0;
              size_p1  <= req_size;
              uns_p1   <= req_unsigned;
              ofs_p1   <= ofs;
              state    <= S_REQ;
            end
          end
        end
        // p1: hold every bus output until granted. A flush before the grant abandons the access.
        S_REQ: begin
          if (da.gnt) begin
            da.req <= 1'b0;
            drop   <= flush;
            state  <= S_RESP;
          end else if (flush) begin
            da.req <= 1'b0;
            state  <= S_IDLE;
          end
        end
        // p1 -> p2: completion. The response is suppressed once a flush has been seen.
        S_RESP: begin
          if (da.rvalid) begin
            if (!(drop || flush)) begin
              resp_valid <= 1'b1;
              resp_rdata <= da.we ? '0
                                  : load_extend(da.rdata >> {ofs_p1, 3'b000}, size_p1, uns_p1);
            end
            drop  <= 1'b0;
            state <= S_IDLE;
          end else if (flush) begin
            drop <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_req_unit.sv
// Bench for mem_req_unit: 32-bit and 64-bit instances share stimulus, and one is selected per access.
// Expected values come from a byte-lane arithmetic model of the load/store rules.
module tb_mem_req_unit;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic        req_valid32, req_valid64;
  logic        req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        gnt, rvalid;
  logic [63:0] rdata;

  logic        ready32, resp_valid32, ale32;
  logic [31:0] rdata32, badv32;
  logic        ready64, resp_valid64, ale64;
  logic [63:0] rdata64;
  logic [31:0] badv64;

  int passes = 0;
  int fails  = 0;
  int checks = 0;
  bit sel = 1'b0;

  always #5 clk = ~clk;

  mem_req_unit_if #(.ADDR_W(32), .DATA_W(32)) if32 ();
  mem_req_unit_if #(.ADDR_W(32), .DATA_W(64)) if64 ();

  assign if32.gnt    = gnt;
  assign if32.rvalid = rvalid;
  assign if32.rdata  = rdata[31:0];
  assign if64.gnt    = gnt;
  assign if64.rvalid = rvalid;
  assign if64.rdata  = rdata;

  mem_req_unit #(.ADDR_W(32), .DATA_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid32), .req_ready(ready32), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]),
    .resp_valid(resp_valid32), .resp_rdata(rdata32), .resp_ale(ale32),
    .resp_badv(badv32), .da(if32.master)
  );

  mem_req_unit #(.ADDR_W(32), .DATA_W(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid64), .req_ready(ready64), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid64), .resp_rdata(rdata64), .resp_ale(ale64),
    .resp_badv(badv64), .da(if64.master)
  );

  logic        o_ready, o_rv, o_ale, o_req, o_we;
  logic [63:0] o_rdata, o_wdata;
  logic [31:0] o_badv, o_addr;
  logic [7:0]  o_strb;

  always_comb begin
    o_ready = sel ? ready64      : ready32;
    o_rv    = sel ? resp_valid64 : resp_valid32;
    o_rdata = sel ? rdata64      : {32'b0, rdata32};
    o_ale   = sel ? ale64        : ale32;
    o_badv  = sel ? badv64       : badv32;
    o_req   = sel ? if64.req     : if32.req;
    o_we    = sel ? if64.we      : if32.we;
    o_strb  = sel ? if64.wstrb   : {4'b0, if32.wstrb};
    o_addr  = sel ? if64.addr    : if32.addr;
    o_wdata = sel ? if64.wdata   : {32'b0, if32.wdata};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Reference model: take the width-limited bus word, shift out the lane, then mask and extend.
  function automatic logic [63:0] model_load(input bit w64, input logic [63:0] rd,
                                             input int size, input bit uns, input int ofs);
    logic [63:0] v, m;
    int nb;
    nb = 8 << size;
    v  = w64 ? rd : (rd & 64'hFFFF_FFFF);
    v  = v >> (8 * ofs);
    if (nb < 64) begin
      m = (64'd1 << nb) - 64'd1;
      v = v & m;
      if (!uns && v[nb-1]) v = v | ~m;
    end
    if (!w64) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic chk_bus(input string tag, input logic req, input logic we,
                         input logic [63:0] strb, input logic [31:0] addr,
                         input logic [63:0] wdata);
    chk({tag, "_da_req"},   {63'b0, o_req}, {63'b0, req});
    chk({tag, "_da_we"},    {63'b0, o_we},  {63'b0, we});
    chk({tag, "_da_wstrb"}, {56'b0, o_strb}, strb);
    chk({tag, "_da_addr"},  {32'b0, o_addr}, {32'b0, addr});
    chk({tag, "_da_wdata"}, o_wdata, wdata);
  endtask

  task automatic chk_resp(input string tag, input logic v, input logic [63:0] rd,
                          input logic ale, input logic [31:0] badv);
    chk({tag, "_resp_valid"}, {63'b0, o_rv},  {63'b0, v});
    chk({tag, "_resp_rdata"}, o_rdata, rd);
    chk({tag, "_resp_ale"},   {63'b0, o_ale}, {63'b0, ale});
    chk({tag, "_resp_badv"},  {32'b0, o_badv}, {32'b0, badv});
  endtask

  task automatic drive_req(input bit w64, input bit we, input int size, input bit uns,
                           input logic [31:0] addr, input logic [63:0] wd);
    sel          = w64;
    req_we       = we;
    req_size     = 2'(size);
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    if (w64) req_valid64 = 1'b1;
    else     req_valid32 = 1'b1;
  endtask

  // One complete access. Called and returns just after a falling edge.
  task automatic do_access(input string tag, input bit w64, input bit we, input int size,
                           input bit uns, input logic [31:0] addr, input logic [63:0] wd,
                           input logic [63:0] rd, input int gd, input int rvd,
                           output logic [63:0] got);
    int bytes, ofs;
    bit mis;
    logic [63:0] wmask, e_strb, e_wdata, e_r;
    logic [31:0] e_addr;
    bytes   = w64 ? 8 : 4;
    ofs     = int'(addr % bytes);
    wmask   = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    mis     = ((addr % (32'd1 << size)) != 0) || (size == 3 && !w64);
    e_strb  = we ? ((((64'd1 << (1 << size)) - 64'd1) << ofs) & (w64 ? 64'hFF : 64'hF)) : 64'd0;
    e_wdata = we ? (((wd & wmask) << (8 * ofs)) & wmask) : 64'd0;
    e_addr  = addr & ~(32'(bytes) - 32'd1);
    e_r     = we ? 64'd0 : model_load(w64, rd, size, uns, ofs);
    got     = 64'd0;

    drive_req(w64, we, size, uns, addr, wd);
    chk({tag, "_ready"}, {63'b0, o_ready}, 64'd1);
    cyc();
    req_valid32 = 1'b0;
    req_valid64 = 1'b0;
    if (mis) begin
      chk_resp({tag, "_ale"}, 1'b1, 64'd0, 1'b1, addr);
      chk({tag, "_no_req"}, {63'b0, o_req}, 64'd0);
      got = o_rdata;
      cyc();
      chk({tag, "_ale_pulse"}, {63'b0, o_rv}, 64'd0);
      return;
    end
    chk_bus({tag, "_issue"}, 1'b1, we, e_strb, e_addr, e_wdata);
    for (int i = 0; i < gd; i++) begin
      cyc();
      chk_bus({tag, "_hold"}, 1'b1, we, e_strb, e_addr, e_wdata);
    end
    gnt = 1'b1;
    cyc();
    gnt = 1'b0;
    chk({tag, "_req_drop"}, {63'b0, o_req}, 64'd0);
    chk({tag, "_early_resp"}, {63'b0, o_rv}, 64'd0);
    for (int i = 0; i < rvd; i++) begin
      cyc();
      chk({tag, "_wait_resp"}, {63'b0, o_rv}, 64'd0);
    end
    rvalid = 1'b1;
    rdata  = rd;
    cyc();
    rvalid = 1'b0;
    rdata  = {$urandom, $urandom};
    chk_resp({tag, "_done"}, 1'b1, e_r, 1'b0, 32'd0);
    got = o_rdata;
    cyc();
    chk_resp({tag, "_after"}, 1'b0, 64'd0, 1'b0, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] got, rd, wd;
    logic [31:0] addr;
    int size;
    rst = 1'b1; flush = 1'b0; req_valid32 = 1'b0; req_valid64 = 1'b0;
    req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;

    repeat (3) cyc();
    for (int w = 0; w < 2; w++) begin
      sel = w[0];
      #1;
      chk_resp("reset", 1'b0, 64'd0, 1'b0, 32'd0);
      chk_bus("reset", 1'b0, 1'b0, 64'd0, 32'd0, 64'd0);
      chk("reset_ready", {63'b0, o_ready}, 64'd0);
    end
    rst = 1'b0;
    cyc();

    // Signed byte load at the earliest grant and response.
    do_access("ldb", 1'b0, 1'b0, 0, 1'b0, 32'h1003, 64'd0, 64'h80AABBCC, 0, 0, got);
    chk("ldb_value", got, 64'hFFFF_FF80);

    // Half store with the grant held off for three cycles.
    do_access("sth", 1'b0, 1'b1, 1, 1'b0, 32'h2002, 64'h1234ABCD, 64'h5555_5555, 3, 1, got);
    chk("sth_value", got, 64'd0);

    do_access("ldw_mis", 1'b0, 1'b0, 2, 1'b0, 32'h3001, 64'd0, 64'd0, 0, 0, got);
    do_access("ldd_32", 1'b0, 1'b0, 3, 1'b1, 32'h1008, 64'd0, 64'd0, 0, 0, got);

    rd = {$urandom, $urandom};
    do_access("ldd_64", 1'b1, 1'b0, 3, 1'b1, 32'hABCD_0008, 64'd0, rd, 1, 2, got);
    chk("ldd_64_value", got, rd);

    // A flush while the request waits for a grant abandons the access.
    sel = 1'b0;
    drive_req(1'b0, 1'b0, 2, 1'b0, 32'h40, 64'd0);
    cyc();
    req_valid32 = 1'b0;
    chk("fl_req_issue", {63'b0, o_req}, 64'd1);
    flush = 1'b1;
    #1 chk("fl_ready_low", {63'b0, o_ready}, 64'd0);
    cyc();
    flush = 1'b0;
    chk("fl_req_drop", {63'b0, o_req}, 64'd0);
    chk("fl_no_resp", {63'b0, o_rv}, 64'd0);
    #1 chk("fl_ready_back", {63'b0, o_ready}, 64'd1);
    rvalid = 1'b1;
    cyc();
    rvalid = 1'b0;
    chk("fl_stray_rvalid", {63'b0, o_rv}, 64'd0);

    // A flush after the grant drops the response.
    drive_req(1'b0, 1'b0, 0, 1'b0, 32'h51, 64'd0);
    cyc();
    req_valid32 = 1'b0;
    gnt = 1'b1;
    cyc();
    gnt = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    rvalid = 1'b1;
    cyc();
    rvalid = 1'b0;
    chk("flr_no_resp", {63'b0, o_rv}, 64'd0);
    chk("flr_idle", {63'b0, o_ready}, 64'd1);
    cyc();
    chk("flr_still_quiet", {63'b0, o_rv}, 64'd0);

    // A flush arriving in the same cycle as the grant also drops the response.
    drive_req(1'b0, 1'b1, 2, 1'b0, 32'h60, 64'hDEAD_BEEF);
    cyc();
    req_valid32 = 1'b0;
    gnt = 1'b1; flush = 1'b1;
    cyc();
    gnt = 1'b0; flush = 1'b0;
    rvalid = 1'b1;
    cyc();
    rvalid = 1'b0;
    chk("flg_no_resp", {63'b0, o_rv}, 64'd0);
    chk("flg_idle", {63'b0, o_ready}, 64'd1);

    // Back-to-back: B is held valid and is accepted in the cycle A responds.
    rd = {32'h0, $urandom};
    drive_req(1'b0, 1'b0, 2, 1'b0, 32'h100, 64'd0);
    cyc();
    drive_req(1'b0, 1'b1, 0, 1'b0, 32'h105, 64'h0000_00A5);
    chk_bus("b2b_a", 1'b1, 1'b0, 64'd0, 32'h100, 64'd0);
    gnt = 1'b1;
    cyc();
    gnt = 1'b0;
    rvalid = 1'b1; rdata = rd;
    chk("b2b_busy", {63'b0, o_ready}, 64'd0);
    cyc();
    rvalid = 1'b0;
    chk_resp("b2b_a_done", 1'b1, model_load(1'b0, rd, 2, 1'b0, 0), 1'b0, 32'd0);
    chk("b2b_ready_in_resp", {63'b0, o_ready}, 64'd1);
    cyc();
    req_valid32 = 1'b0;
    chk("b2b_pulse", {63'b0, o_rv}, 64'd0);
    chk_bus("b2b_b", 1'b1, 1'b1, 64'h2, 32'h104, 64'h0000_A500);
    gnt = 1'b1;
    cyc();
    gnt = 1'b0;
    rvalid = 1'b1;
    cyc();
    rvalid = 1'b0;
    chk_resp("b2b_b_done", 1'b1, 64'd0, 1'b0, 32'd0);
    cyc();

    // Reset while waiting for read data. A later rvalid must be ignored.
    drive_req(1'b0, 1'b1, 2, 1'b0, 32'h200, 64'h1111_2222);
    cyc();
    req_valid32 = 1'b0;
    gnt = 1'b1;
    cyc();
    gnt = 1'b0;
    rst = 1'b1;
    #1 chk("rst_ready", {63'b0, o_ready}, 64'd0);
    cyc();
    chk_resp("rst_mid", 1'b0, 64'd0, 1'b0, 32'd0);
    chk_bus("rst_mid", 1'b0, 1'b0, 64'd0, 32'd0, 64'd0);
    rst = 1'b0;
    rvalid = 1'b1;
    cyc();
    rvalid = 1'b0;
    chk("rst_stray", {63'b0, o_rv}, 64'd0);
    chk("rst_idle", {63'b0, o_ready}, 64'd1);

    // Randomized accesses on both widths.
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 30; i++) begin
        size = int'($urandom_range(0, 3));
        addr = $urandom;
        if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
        wd = {$urandom, $urandom};
        rd = {$urandom, $urandom};
        do_access(w[0] ? "rnd64" : "rnd32", w[0], 1'($urandom_range(0, 1)), size,
                  1'($urandom_range(0, 1)), addr, wd, rd,
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), got);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mem_req_unit.md
Name: mem_req_unit

Overview:
Parametrised load/store request unit between the EX/MEM pipeline boundary and the data-side bus.
- Upstream: valid/ready request interface.
- Downstream: request/grant plus response-valid handshake. Every bus output is held stable until granted.
- Generates byte strobes and lane-shifted write data, detects misaligned accesses, and aligns plus sign/zero-extends load data.
- Supports a pipeline flush that cancels or drops in-flight accesses.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, bus data width; legal values 32 or 64; BYTES = DATA_W/8, OFS_W = log2(BYTES)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  cancel or drop the current access
req_valid  in  1  request from pipeline
req_ready  out  1  unit can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 byte, 1 half, 2 word, 3 dword (dword legal only when DATA_W=64)
req_unsigned  in  1  zero-extend load result
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  extended load data; 0 for stores
resp_ale  out  1  address-alignment exception
resp_badv  out  ADDR_W  faulting address when resp_ale=1, else 0
da_req  out  1  bus request
da_gnt  in  1  bus accepted request
da_we  out  1  bus write
da_wstrb  out  BYTES  byte write strobes; 0 for loads
da_addr  out  ADDR_W  address with low OFS_W bits cleared
da_wdata  out  DATA_W  lane-shifted store data
da_rvalid  in  1  read data / write acknowledge
da_rdata  in  DATA_W  read data, full bus word

Behaviour:
- Reset: state IDLE. resp_valid, resp_rdata, resp_ale, resp_badv, da_req, da_we, da_wstrb, da_addr and da_wdata are all 0; drop flag cleared. req_ready=0 while rst=1.
- req_ready = (state==IDLE) & !flush & !rst. Accept occurs on req_valid & req_ready.
- Misalignment is true when req_addr & ((1<<req_size)-1) != 0, or when req_size==3 with DATA_W=32.
- IDLE, misaligned accept:
  - No bus request is issued.
  - Next cycle: resp_valid=1, resp_ale=1, resp_badv=req_addr, resp_rdata=0.
  - State stays IDLE.
- IDLE, aligned accept:
  - Register da_addr, da_we=req_we.
  - Stores: da_wstrb = ((1<<(1<<req_size))-1) << ofs; da_wdata = req_wdata << (8*ofs), where ofs = req_addr[OFS_W-1:0].
  - Loads: da_wstrb=0, da_wdata=0.
  - Latch size, unsigned and ofs for the response. da_req=1 next cycle. Go to REQ.
- REQ: da_req=1. All da_* outputs stay constant until da_gnt.
  - da_gnt=1: da_req=0 next cycle; go to RESP.
  - flush=1 and da_gnt=0: abandon the request; da_req=0 next cycle; go to IDLE; no response.
  - flush=1 and da_gnt=1 in the same cycle: go to RESP with drop flag set.
- RESP: wait for da_rvalid. flush in RESP sets the drop flag.
  - On da_rvalid with drop clear: next cycle resp_valid=1, resp_ale=0.
  - Load result: extract 8<<size bits at da_rdata >> (8*ofs), then sign-extend (req_unsigned=0) or zero-extend to DATA_W.
  - Store result: resp_rdata=0.
  - On da_rvalid with drop set: no resp_valid; clear drop.
  - Either case: go to IDLE.
- resp_valid is a single-cycle pulse. resp_rdata, resp_ale and resp_badv are 0 whenever resp_valid=0.
- Minimum aligned latency, counted from accept at cycle T: da_req at T+1; with da_gnt at T+1 and da_rvalid at T+2, resp_valid at T+3.
- A new request may be accepted in the same cycle resp_valid is high, because the state is already IDLE.
- da_rvalid outside RESP is ignored. da_gnt outside REQ is ignored.
- One outstanding access at a time. Unbounded gnt/rvalid wait; no timeout.
- rst mid-operation returns to IDLE immediately; any later da_rvalid is ignored.

Test Plan:
- DATA_W=32, load byte signed, addr 0x1003, da_rdata 0x80AABBCC -> da_addr 0x1000, da_wstrb 0; resp_rdata 0xFFFFFF80; resp_valid 3 cycles after accept with gnt/rvalid at earliest.
- DATA_W=32, store half, addr 0x2002, wdata 0x1234ABCD -> da_wstrb 4'b1100, da_wdata 0xABCD0000, da_we=1, outputs held through 3 cycles of da_gnt=0; resp_valid after da_rvalid, resp_rdata 0.
- Load word at 0x3001 -> no da_req; next cycle resp_valid=1, resp_ale=1, resp_badv 0x00003001.
- DATA_W=64, load dword unsigned at 0x...08 -> da_wstrb 0, resp_rdata = da_rdata. Load dword with DATA_W=32 -> resp_ale=1.
- flush during REQ with da_gnt=0 -> da_req drops next cycle, no resp_valid, req_ready=1 afterwards. flush in RESP -> later da_rvalid yields no resp_valid and state returns to IDLE.
- Back-to-back: second req_valid held high while first completes -> accepted in the resp_valid cycle. rst asserted in RESP -> all outputs 0, stray da_rvalid ignored.
